prog_loader_ctrl: RTL and testbench

Sequences in-system reprogramming of the instruction memory from the programming UART byte stream. It parses a framed image, packs bytes into 32-bit little-endian words and drives the imem write port. It holds the core's PC in reset for the duration of a load and answers each frame with an ACK/NAK byte. It sits between the programming-UART receiver/transmitter and the imem/riscvsingle reset inputs in `top`.

---
 rtl/prog_loader_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_prog_loader_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader_ctrl.sv
// -----------------------------------------------------------------------------
// prog_loader_ctrl
//
// Sequences in-system reprogramming of the instruction memory from the
// programming-UART byte stream. A frame is
//   SYNC, LEN_LO, LEN_HI, 4*N payload bytes (LSB first per word) [, CHK]
// Payload bytes are packed into 32-bit little-endian words and written to
// imem word addresses 0..N-1. The core's PC is held in reset for the whole
// load, and each frame is answered with an ACK (8'h06) or NAK (8'h15) byte.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
//   defined   - a trailing CHK byte is expected; the frame is accepted when
//               (LEN_LO + LEN_HI + payload + CHK) mod 256 == 0.
//   undefined - no CHK byte; ACK follows the last payload byte.
//
// Parameters
//   IMEM_AW      imem word-address width (depth = 2**IMEM_AW words)
//   TIMEOUT_CYC  max idle cycles between bytes inside a frame
//   SYNC_BYTE    frame start marker
//
// Ports
//   clk         system clock
//   rst         asynchronous active-low reset
//   rx_valid    one-cycle strobe, rx_data valid
//   rx_data     received byte
//   imem_we     registered one-cycle word write strobe
//   imem_addr   word address
//   imem_wdata  word to write
//   cpu_hold    holds the core's PC in reset while high
//   busy        high in every state other than IDLE
//   err         sticky error flag, cleared by the next accepted SYNC
//   tx_valid    response byte available
//   tx_data     response byte (ACK 8'h06 / NAK 8'h15)
//   tx_ready    transmitter accepts tx_data
// -----------------------------------------------------------------------------
module prog_loader_ctrl #(
    parameter int          IMEM_AW     = 8,
    parameter int          TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               cpu_hold,
    output logic               busy,
    output logic               err,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    input  logic               tx_ready
);

    localparam logic [7:0]  ACK_BYTE  = 8'h06;
    localparam logic [7:0]  NAK_BYTE  = 8'h15;
    localparam int          TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [16:0] MAX_WORDS = 17'd1 << IMEM_AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CHK,
        S_RESP,
        S_ERRW
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        len_q,   len_d;
    logic [IMEM_AW-1:0] addr_q,  addr_d;
    logic [1:0]         lane_q,  lane_d;
    logic [15:0]        wcnt_q,  wcnt_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               we_q,    we_d;
    logic [7:0]         sum_q,   sum_d;
    logic [TW-1:0]      tmo_q,   tmo_d;
    logic               hold_q,  hold_d;
    logic               err_q,   err_d;
    logic               txv_q,   txv_d;
    logic [7:0]         txd_q,   txd_d;

    logic               in_frame;
    logic               tmo_fire;
    logic [15:0]        new_len;
    logic               last_word;

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path leaves a value unassigned and no latch is inferred.
        state_d  = state_q;
        len_d    = len_q;
        addr_d   = addr_q;
        lane_d   = lane_q;
        wcnt_d   = wcnt_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        sum_d    = sum_q;
        tmo_d    = tmo_q;
        hold_d   = hold_q;
        err_d    = err_q;
        txd_d    = txd_q;
        tmo_fire = 1'b0;

        new_len   = {rx_data, len_q[7:0]};
        last_word = (({1'b0, wcnt_q} + 17'd1) == {1'b0, len_q});
        in_frame  = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                    (state_q == S_DATA) || (state_q == S_CHK);

        // Idle-gap counter: a byte always wins over an expiring count.
        if (in_frame) begin
            if (rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_fire = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        // The address advances in the cycle after the write pulse, so it is
        // stable while imem_we is high.
        if (we_q) begin
            addr_d = addr_q + IMEM_AW'(1);
        end

        unique case (state_q)
            S_IDLE, S_ERRW: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = S_LEN0;
                    hold_d  = 1'b1;
                    err_d   = 1'b0;
                    addr_d  = '0;
                    lane_d  = '0;
                    wcnt_d  = '0;
                    sum_d   = '0;
                    tmo_d   = '0;
                end
            end

            S_LEN0: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    sum_d      = sum_q + rx_data;
                    state_d    = S_LEN1;
                end
            end

            S_LEN1: begin
                if (rx_valid) begin
                    len_d[15:8] = rx_data;
                    sum_d       = sum_q + rx_data;
                    if ((new_len == 16'd0) || ({1'b0, new_len} > MAX_WORDS)) begin
                        err_d   = 1'b1;
                        txd_d   = NAK_BYTE;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (rx_valid) begin
                    wdata_d[{lane_q, 3'b000} +: 8] = rx_data;
                    sum_d  = sum_q + rx_data;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        we_d   = 1'b1;
                        wcnt_d = wcnt_q + 16'd1;
                        if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            txd_d   = ACK_BYTE;
                            state_d = S_RESP;
`endif
                        end
                    end
                end
            end

            S_CHK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (rx_valid) begin
                    if ((sum_q + rx_data) == 8'd0) begin
                        txd_d = ACK_BYTE;
                    end else begin
                        txd_d = NAK_BYTE;
                        err_d = 1'b1;
                    end
                    state_d = S_RESP;
                end
`else
                state_d = S_IDLE;
`endif
            end

            S_RESP: begin
                // Incoming bytes are dropped here; only the handshake matters.
                if (tx_ready) begin
                    if (txd_q == ACK_BYTE) begin
                        hold_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        // Image is partially overwritten: keep the core held.
                        state_d = S_ERRW;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Timeout only fires on a byte-free cycle, so it never collides with
        // the byte handling above; any partial word is simply abandoned.
        if (tmo_fire) begin
            err_d   = 1'b1;
            txd_d   = NAK_BYTE;
            state_d = S_RESP;
        end

        txv_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            lane_q  <= '0;
            wcnt_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sum_q   <= '0;
            tmo_q   <= '0;
            hold_q  <= 1'b0;
            err_q   <= 1'b0;
            txv_q   <= 1'b0;
            txd_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples
            // the pre-edge values and the update order inside the block is
            // irrelevant.
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            wcnt_q  <= wcnt_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            sum_q   <= sum_d;
            tmo_q   <= tmo_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            txv_q   <= txv_d;
            txd_q   <= txd_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;
    assign tx_valid   = txv_q;
    assign tx_data    = txd_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prog_loader_ctrl
//
// Directed bench for prog_loader_ctrl. A frame-level model turns each frame
// into the list of imem writes and the response byte it must produce; a
// compare process checks every write pulse and every response transfer
// against that model. Literal expectations pin the model on the first load.
// Builds with or without PROG_LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_prog_loader_ctrl;

    localparam int         AW   = 8;
    localparam int         TMO  = 40;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;
    localparam int         RESP_BUDGET = 4 * TMO + 200;

    typedef logic [7:0] bq_t[$];
    typedef logic [31:0] wq_t[$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          err;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;

    prog_loader_ctrl #(
        .IMEM_AW     (AW),
        .TIMEOUT_CYC (TMO),
        .SYNC_BYTE   (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .err        (err),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    wr_t        exp_wr[$];
    wr_t        wr_log[$];
    logic [7:0] exp_resp[$];
    logic [7:0] resp_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame model ----------------
    // From the frame bytes alone: which words land where, and ACK or NAK.
    // A frame shorter than its length field implies an idle gap (timeout).
    function automatic void model_frame(input bq_t f);
        int         n;
        logic [7:0] s;
        n = int'({f[2], f[1]});
        if (n == 0 || n > (1 << AW)) begin
            exp_resp.push_back(NAK);
            return;
        end
        for (int w = 0; w < n; w++) begin
            if (f.size() < 3 + 4 * w + 4) begin
                exp_resp.push_back(NAK);
                return;
            end
            exp_wr.push_back({AW'(w), f[3+4*w+3], f[3+4*w+2], f[3+4*w+1], f[3+4*w]});
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (f.size() < 3 + 4 * n + 1) begin
            exp_resp.push_back(NAK);
            return;
        end
        s = 8'd0;
        for (int i = 1; i <= 3 + 4 * n; i++) s = s + f[i];
        exp_resp.push_back((s == 8'd0) ? ACK : NAK);
`else
        exp_resp.push_back(ACK);
`endif
    endfunction

    function automatic bq_t build_frame(input wq_t words, input bit bad_chk);
        bq_t        f;
        logic [7:0] s;
        logic [31:0] w;
        f.push_back(SYNC);
        f.push_back(8'(words.size()));
        f.push_back(8'(words.size() >> 8));
        foreach (words[i]) begin
            w = words[i];
            for (int b = 0; b < 4; b++) f.push_back(w[8*b +: 8]);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        s = 8'd0;
        for (int i = 1; i < f.size(); i++) s = s + f[i];
        s = 8'd0 - s;
        if (bad_chk) s = s + 8'd1;
        f.push_back(s);
`else
        if (bad_chk) f.push_back(8'h00);
`endif
        return f;
    endfunction

    // ---------------- compare process ----------------
    logic       pend;
    logic [7:0] pend_data;
    wr_t        cmp_w;
    logic [7:0] cmp_r;

    always @(negedge clk) begin
        if (!rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                check("tx_valid_held", tx_valid, 1);
                check("tx_data_held", tx_data, pend_data);
            end
            pend      = tx_valid && !tx_ready;
            pend_data = tx_data;
            if (imem_we) begin
                wr_log.push_back({imem_addr, imem_wdata});
                check("we_under_hold", cpu_hold, 1);
                check("write_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    cmp_w = exp_wr.pop_front();
                    check("wr_addr", imem_addr, cmp_w.addr);
                    check("wr_data", imem_wdata, cmp_w.data);
                end
            end
            if (tx_valid && tx_ready) begin
                resp_log.push_back(tx_data);
                check("resp_expected", exp_resp.size() > 0, 1);
                if (exp_resp.size() > 0) begin
                    cmp_r = exp_resp.pop_front();
                    check("resp_byte", tx_data, cmp_r);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // All helpers start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bq_t f);
        model_frame(f);
        send_byte(f[0]);
        check("hold_after_sync", cpu_hold, 1);
        check("busy_after_sync", busy, 1);
        for (int i = 1; i < f.size(); i++) send_byte(f[i]);
    endtask

    task automatic wait_resp(input bit ack);
        int k;
        k = 0;
        while (!(tx_valid && tx_ready) && k < RESP_BUDGET) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("resp_seen", tx_valid && tx_ready, 1);
        if (tx_valid && tx_ready) begin
            check("hold_in_xfer", cpu_hold, 1);
            @(posedge clk);
            #1;
            check("tx_valid_drop", tx_valid, 0);
            check("hold_after_resp", cpu_hold, ack ? 0 : 1);
            check("err_after_resp", err, ack ? 0 : 1);
            check("busy_after_resp", busy, ack ? 0 : 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, imem_we, 0);
        check({tag, "_addr"}, imem_addr, 0);
        check({tag, "_wdata"}, imem_wdata, 0);
        check({tag, "_hold"}, cpu_hold, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_txv"}, tx_valid, 0);
        check({tag, "_txd"}, tx_data, 0);
    endtask

    // ---------------- directed sequence ----------------
    bq_t f;
    wq_t words;

    initial begin
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Non-SYNC bytes in IDLE are ignored.
        send_byte(8'h13);
        send_byte(8'h00);
        check("idle_ignore_busy", busy, 0);
        check("idle_ignore_hold", cpu_hold, 0);

        // Good load.
        words = '{32'h00500013, 32'h00100093};
        f = build_frame(words, 1'b0);
        wr_log.delete();
        send_frame(f);
        wait_resp(1'b1);
        check("lit_wr_count", wr_log.size(), 2);
        check("lit_w0_addr", wr_log[0].addr, 0);
        check("lit_w0_data", wr_log[0].data, 32'h00500013);
        check("lit_w1_addr", wr_log[1].addr, 1);
        check("lit_w1_data", wr_log[1].data, 32'h00100093);
        check("lit_ack", resp_log[resp_log.size()-1], ACK);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Bad checksum: both words land, NAK, core stays held until a good frame.
        f = build_frame(words, 1'b1);
        wr_log.delete();
        send_frame(f);
        wait_resp(1'b0);
        check("badchk_wr_count", wr_log.size(), 2);
        check("lit_badchk_nak", resp_log[resp_log.size()-1], NAK);
        repeat (3) @(posedge clk);
        #1;
        check("badchk_hold_stays", cpu_hold, 1);
        f = build_frame(words, 1'b0);
        send_frame(f);
        wait_resp(1'b1);
`endif

        // Bad lengths: NAK right after LEN_HI, no writes.
        f = '{SYNC, 8'h00, 8'h00};
        send_frame(f);
        check("len0_txv_now", tx_valid, 1);
        check("len0_nak_now", tx_data, NAK);
        wait_resp(1'b0);
        f = '{SYNC, 8'h01, 8'h01};
        send_frame(f);
        check("len257_txv_now", tx_valid, 1);
        check("len257_nak_now", tx_data, NAK);
        wait_resp(1'b0);

        // Single word whose bytes all equal SYNC: treated as data.
        words = '{32'hA5A5A5A5};
        f = build_frame(words, 1'b0);
        wr_log.delete();
        send_frame(f);
        wait_resp(1'b1);
        check("sync_in_payload", wr_log[0].data, 32'hA5A5A5A5);

        // Timeout after 5 payload bytes: word 0 only, NAK after TMO idle cycles.
        f = '{SYNC, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93};
        wr_log.delete();
        send_frame(f);
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("tmo_not_yet", tx_valid, 0);
        @(posedge clk);
        #1;
        check("tmo_fired", tx_valid, 1);
        wait_resp(1'b0);
        check("tmo_wr_count", wr_log.size(), 1);
        check("tmo_w0_data", wr_log[0].data, 32'h00500013);

        // Back-to-back bytes with the transmitter stalled for 10 cycles.
        tx_ready = 1'b0;
        words = '{32'h11223344, 32'hA5A5A5A5, 32'hDEADBEEF};
        f = build_frame(words, 1'b0);
        send_frame(f);
        for (int i = 0; i < 10; i++) begin
            check("b2b_txv", tx_valid, 1);
            check("b2b_txd", tx_data, ACK);
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b1;
        wait_resp(1'b1);

        // Reset in the middle of word 1.
        f = '{SYNC, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hAA, 8'hBB};
        send_frame(f);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_resp.delete();
        check("midrst_word0_written", exp_wr.size(), 0);
        exp_wr.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        words = '{32'hCAFEF00D, 32'h0BADBEEF};
        f = build_frame(words, 1'b0);
        send_frame(f);
        wait_resp(1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("all_writes_seen", exp_wr.size(), 0);
        check("all_resps_seen", exp_resp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
